// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one combinational alu32 between the EX-stage
// issue path (port 0) and the branch/address-compute path (port 1).
// Round-robin grant, one-cycle capture into a single response slot, and
// screening of func codes against the supported DLX set.
module alu_share_arbiter #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       FUNC_W    = 6,
    parameter logic [FUNC_W-1:0] IDLE_FUNC = FUNC_W'(6'b100000)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_d1,
    input  logic [DATA_W-1:0] r0_d2,
    input  logic [FUNC_W-1:0] r0_func,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_d1,
    input  logic [DATA_W-1:0] r1_d2,
    input  logic [FUNC_W-1:0] r1_func,

    output logic [DATA_W-1:0] alu_d1,
    output logic [DATA_W-1:0] alu_d2,
    output logic [FUNC_W-1:0] alu_func,
    input  logic [DATA_W-1:0] alu_s,
    input  logic              alu_cout,
    input  logic              alu_ovf,
    input  logic              alu_zero,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_s,
    output logic              rsp_cout,
    output logic              rsp_ovf,
    output logic              rsp_zero,
    output logic              rsp_illegal
);

    // Supported func code boundaries
    localparam logic [FUNC_W-1:0] F_SLL     = FUNC_W'(6'b000100);
    localparam logic [FUNC_W-1:0] F_SRL     = FUNC_W'(6'b000110);
    localparam logic [FUNC_W-1:0] F_SRA     = FUNC_W'(6'b000111);
    localparam logic [FUNC_W-1:0] F_ARITH_L = FUNC_W'(6'b100000);
    localparam logic [FUNC_W-1:0] F_ARITH_H = FUNC_W'(6'b100110);
    localparam logic [FUNC_W-1:0] F_SET_L   = FUNC_W'(6'b101000);
    localparam logic [FUNC_W-1:0] F_SET_H   = FUNC_W'(6'b101101);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e              state_q,       state_d;
    logic                rr_ptr_q,      rr_ptr_d;
    logic                rsp_id_q,      rsp_id_d;
    logic [DATA_W-1:0]   rsp_s_q,       rsp_s_d;
    logic                rsp_cout_q,    rsp_cout_d;
    logic                rsp_ovf_q,     rsp_ovf_d;
    logic                rsp_zero_q,    rsp_zero_d;
    logic                rsp_illegal_q, rsp_illegal_d;

    logic                slot_free;
    logic                grant_en;
    logic                gnt0;
    logic                gnt1;
    logic                gnt_any;
    logic [DATA_W-1:0]   sel_d1;
    logic [DATA_W-1:0]   sel_d2;
    logic [FUNC_W-1:0]   sel_func;
    logic                sel_legal;

    // True when f is one of the func codes alu32 implements
    function automatic logic func_legal(input logic [FUNC_W-1:0] f);
        func_legal = (f == F_SLL) || (f == F_SRL) || (f == F_SRA)
                  || ((f >= F_ARITH_L) && (f <= F_ARITH_H))
                  || ((f >= F_SET_L)   && (f <= F_SET_H));
    endfunction

    // Round-robin grant; only offered when the slot can accept a result
    always_comb begin
        slot_free = (state_q == ST_EMPTY) || rsp_ready;
        grant_en  = slot_free && !reset;
        gnt0      = grant_en && r0_valid && (!r1_valid || !rr_ptr_q);
        gnt1      = grant_en && r1_valid && (!r0_valid ||  rr_ptr_q);
        gnt_any   = gnt0 || gnt1;
    end

    assign r0_ready = gnt0;
    assign r1_ready = gnt1;

    // Route the granted request to the ALU; idle add keeps alu32 on a listed code
    always_comb begin
        sel_d1   = '0;
        sel_d2   = '0;
        sel_func = IDLE_FUNC;
        if (gnt0) begin
            sel_d1   = r0_d1;
            sel_d2   = r0_d2;
            sel_func = r0_func;
        end else if (gnt1) begin
            sel_d1   = r1_d1;
            sel_d2   = r1_d2;
            sel_func = r1_func;
        end
        sel_legal = func_legal(sel_func);
        alu_d1    = sel_d1;
        alu_d2    = sel_d2;
        alu_func  = (gnt_any && sel_legal) ? sel_func : IDLE_FUNC;
    end

    // Slot FSM next-state plus response capture and pointer update
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        rsp_id_d      = rsp_id_q;
        rsp_s_d       = rsp_s_q;
        rsp_cout_d    = rsp_cout_q;
        rsp_ovf_d     = rsp_ovf_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_illegal_d = rsp_illegal_q;

        case (state_q)
            ST_EMPTY: begin
                if (gnt_any) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (gnt_any) begin
                    state_d = ST_FULL;
                end else if (rsp_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (gnt_any) begin
            rr_ptr_d      = !gnt1;
            rsp_id_d      = gnt1;
            rsp_illegal_d = !sel_legal;
            // An illegal request still completes, but with a cleared result
            rsp_s_d       = sel_legal ? alu_s    : '0;
            rsp_cout_d    = sel_legal && alu_cout;
            rsp_ovf_d     = sel_legal && alu_ovf;
            rsp_zero_d    = sel_legal && alu_zero;
        end
    end

    // State and response registers; reset discards any pending response
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_EMPTY;
            rr_ptr_q      <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_s_q       <= '0;
            rsp_cout_q    <= 1'b0;
            rsp_ovf_q     <= 1'b0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            rsp_id_q      <= rsp_id_d;
            rsp_s_q       <= rsp_s_d;
            rsp_cout_q    <= rsp_cout_d;
            rsp_ovf_q     <= rsp_ovf_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign rsp_valid   = (state_q == ST_FULL);
    assign rsp_id      = rsp_id_q;
    assign rsp_s       = rsp_s_q;
    assign rsp_cout    = rsp_cout_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_illegal = rsp_illegal_q;

    // Grants are mutually exclusive and never issued into a blocked slot
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(gnt0 && gnt1));
            assert (!(gnt_any && !slot_free));
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural alu32 stand-in, a response
// scoreboard, a table of single-request vectors and directed corner sequences.
module tb_alu_share_arbiter;

    localparam logic [5:0] IDLE = 6'b100000;

    logic        clk;
    logic        reset;
    logic        r0_valid, r0_ready, r1_valid, r1_ready;
    logic [31:0] r0_d1, r0_d2, r1_d1, r1_d2;
    logic [5:0]  r0_func, r1_func;
    logic [31:0] alu_d1, alu_d2, alu_s;
    logic [5:0]  alu_func;
    logic        alu_cout, alu_ovf, alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_s;
    logic        rsp_cout, rsp_ovf, rsp_zero, rsp_illegal;

    alu_share_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_d1(r0_d1), .r0_d2(r0_d2), .r0_func(r0_func),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_d1(r1_d1), .r1_d2(r1_d2), .r1_func(r1_func),
        .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_func(alu_func),
        .alu_s(alu_s), .alu_cout(alu_cout), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s),
        .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // alu32 stand-in: add/sub with carry/overflow, logic ops; other codes add
    logic [32:0] t;
    always_comb begin
        t        = {1'b0, alu_d1} + {1'b0, alu_d2};
        alu_s    = t[31:0];
        alu_cout = t[32];
        alu_ovf  = (alu_d1[31] == alu_d2[31]) && (t[31] != alu_d1[31]);
        case (alu_func)
            6'b100010, 6'b100011: begin
                t        = {1'b0, alu_d1} + {1'b0, ~alu_d2} + 33'd1;
                alu_s    = t[31:0];
                alu_cout = t[32];
                alu_ovf  = (alu_d1[31] != alu_d2[31]) && (t[31] != alu_d1[31]);
            end
            6'b100100: begin alu_s = alu_d1 & alu_d2; alu_cout = 1'b0; alu_ovf = 1'b0; end
            6'b100101: begin alu_s = alu_d1 | alu_d2; alu_cout = 1'b0; alu_ovf = 1'b0; end
            6'b100110: begin alu_s = alu_d1 ^ alu_d2; alu_cout = 1'b0; alu_ovf = 1'b0; end
            default: ;
        endcase
        alu_zero = (alu_s == 32'd0);
    end

    typedef struct packed {
        logic        id;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        ill;
    } rsp_t;

    typedef struct {
        logic        port;
        logic [5:0]  func;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        ill;
    } vec_t;

    rsp_t sb_q[$];
    rsp_t exp0, exp1;
    logic granted_prev;
    int   n_checks;
    int   n_errors;
    vec_t vecs[12];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare a consumed response, then record grants made this cycle
    task automatic sb_step();
        rsp_t e;
        if (granted_prev) chk1("rsp_latency", rsp_valid, 1'b1);
        chk1("ready_onehot", r0_ready & r1_ready, 1'b0);
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected_rsp: got rsp_s 0x%0h expected no response", rsp_s);
            end else begin
                e = sb_q.pop_front();
                chk1 ("rsp_id",      rsp_id,      e.id);
                chk32("rsp_s",       rsp_s,       e.s);
                chk1 ("rsp_cout",    rsp_cout,    e.cout);
                chk1 ("rsp_ovf",     rsp_ovf,     e.ovf);
                chk1 ("rsp_zero",    rsp_zero,    e.zero);
                chk1 ("rsp_illegal", rsp_illegal, e.ill);
            end
        end
        granted_prev = 1'b0;
        if (r0_valid && r0_ready) begin sb_q.push_back(exp0); granted_prev = 1'b1; end
        if (r1_valid && r1_ready) begin sb_q.push_back(exp1); granted_prev = 1'b1; end
    endtask

    task automatic drive(input logic port, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input rsp_t e);
        if (port == 1'b0) begin
            r0_valid = 1'b1; r0_func = f; r0_d1 = a; r0_d2 = b; exp0 = e;
        end else begin
            r1_valid = 1'b1; r1_func = f; r1_d1 = a; r1_d2 = b; exp1 = e;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            chk1 ("rst_r0_ready", r0_ready, 1'b0);
            chk1 ("rst_r1_ready", r1_ready, 1'b0);
            chk32("rst_alu_func", 32'(alu_func), 32'(IDLE));
            chk32("rst_alu_d1",   alu_d1, 32'd0);
            @(negedge clk);
        end
        reset = 1'b0;
        sb_q.delete();
        granted_prev = 1'b0;
    endtask

    task automatic idle_step();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        #1;
        sb_step();
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; granted_prev = 1'b0;
        reset = 1'b1; rsp_ready = 1'b0;
        r0_valid = 1'b1; r0_d1 = 32'h55; r0_d2 = 32'h66; r0_func = 6'b100010;
        r1_valid = 1'b1; r1_d1 = 32'h77; r1_d2 = 32'h88; r1_func = 6'b100100;
        exp0 = '0; exp1 = '0;

        // port, func, d1, d2 | s, cout, ovf, zero, illegal
        vecs[0]  = '{1'b0, 6'b100000, 32'd5,        32'd7,      32'd12,       1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 6'b100000, 32'h7FFFFFFF, 32'd1,      32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 6'b100010, 32'd5,        32'd5,      32'd0,        1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 6'b111111, 32'd3,        32'd4,      32'd0,        1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 6'b100000, 32'hFFFFFFFF, 32'd1,      32'd0,        1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 6'b000101, 32'd1,        32'd1,      32'd0,        1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 6'b101110, 32'd1,        32'd1,      32'd0,        1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 6'b100111, 32'd2,        32'd2,      32'd0,        1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 6'b100101, 32'd1,        32'd2,      32'd3,        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 6'b101101, 32'd0,        32'd0,      32'd0,        1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 6'b000100, 32'd0,        32'd0,      32'd0,        1'b0, 1'b0, 1'b1, 1'b0};

        @(negedge clk);
        do_reset(2);

        // Post-reset state
        r0_valid = 1'b0; r1_valid = 1'b0;
        #1;
        chk1 ("reset_rsp_valid",   rsp_valid,   1'b0);
        chk32("reset_rsp_s",       rsp_s,       32'd0);
        chk1 ("reset_rsp_illegal", rsp_illegal, 1'b0);
        chk32("idle_alu_func",     32'(alu_func), 32'(IDLE));
        @(negedge clk);

        // Single-request vectors from the table
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].port, vecs[i].func, vecs[i].d1, vecs[i].d2,
                  '{vecs[i].port, vecs[i].s, vecs[i].cout, vecs[i].ovf, vecs[i].zero, vecs[i].ill});
            #1;
            chk1 ("vec_ready", vecs[i].port ? r1_ready : r0_ready, 1'b1);
            chk1 ("vec_other_ready", vecs[i].port ? r0_ready : r1_ready, 1'b0);
            chk32("vec_alu_func", 32'(alu_func), 32'(vecs[i].ill ? IDLE : vecs[i].func));
            chk32("vec_alu_d1", alu_d1, vecs[i].d1);
            sb_step();
            @(negedge clk);
            idle_step();
        end

        // Round robin from reset: grants 0,1,0,1
        do_reset(1);
        rsp_ready = 1'b1;
        drive(1'b0, 6'b100000, 32'd1,  32'd1,  '{1'b0, 32'd2,  1'b0, 1'b0, 1'b0, 1'b0});
        drive(1'b1, 6'b100000, 32'd10, 32'd10, '{1'b1, 32'd20, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int c = 0; c < 4; c++) begin
            #1;
            chk1("rr_r0_ready", r0_ready, (c % 2) == 0);
            chk1("rr_r1_ready", r1_ready, (c % 2) == 1);
            sb_step();
            @(negedge clk);
        end
        idle_step();

        // Backpressure: slot full with 0x10, consumer stalls 3 cycles
        rsp_ready = 1'b0;
        drive(1'b0, 6'b100000, 32'd8, 32'd8, '{1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0});
        #1;
        chk1("bp_fill_ready", r0_ready, 1'b1);
        sb_step();
        @(negedge clk);
        r0_valid = 1'b0;
        drive(1'b1, 6'b100000, 32'h100, 32'h1, '{1'b1, 32'h101, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int c = 0; c < 3; c++) begin
            #1;
            chk1 ("bp_r1_ready",  r1_ready,  1'b0);
            chk1 ("bp_rsp_valid", rsp_valid, 1'b1);
            chk32("bp_rsp_s",     rsp_s,     32'h10);
            chk1 ("bp_rsp_id",    rsp_id,    1'b0);
            sb_step();
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk1("bp_release_ready", r1_ready, 1'b1);
        sb_step();
        @(negedge clk);
        r1_valid = 1'b0;
        #1;
        chk32("bp_next_rsp_s", rsp_s, 32'h101);
        sb_step();
        @(negedge clk);
        #1;
        chk1("drain_empty", rsp_valid, 1'b0);
        @(negedge clk);

        // Reset mid-operation: slot full, rr_ptr pointing at port 1
        rsp_ready = 1'b0;
        drive(1'b0, 6'b100000, 32'd2, 32'd3, '{1'b0, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0});
        #1;
        chk1("mid_fill_ready", r0_ready, 1'b1);
        sb_step();
        @(negedge clk);
        r0_valid = 1'b0;
        drive(1'b1, 6'b100000, 32'd9, 32'd9, '{1'b1, 32'd18, 1'b0, 1'b0, 1'b0, 1'b0});
        #1;
        chk32("mid_full_rsp_s", rsp_s, 32'd5);
        do_reset(1);
        r1_valid = 1'b0;
        #1;
        chk1 ("mid_rsp_valid", rsp_valid, 1'b0);
        chk32("mid_rsp_s",     rsp_s,     32'd0);
        chk1 ("mid_rsp_id",    rsp_id,    1'b0);
        chk1 ("mid_rsp_zero",  rsp_zero,  1'b0);
        rsp_ready = 1'b1;
        drive(1'b0, 6'b100000, 32'd4, 32'd4, '{1'b0, 32'd8,  1'b0, 1'b0, 1'b0, 1'b0});
        drive(1'b1, 6'b100000, 32'd6, 32'd6, '{1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0});
        #1;
        chk1("mid_first_r0", r0_ready, 1'b1);
        chk1("mid_first_r1", r1_ready, 1'b0);
        sb_step();
        @(negedge clk);
        idle_step();
        idle_step();

        chk32("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
